// File: rtl/divrebuild_pkg.sv
// Shared types and widths for the dividend rebuild unit (quotient*divider + remainder).
package divrebuild_pkg;

    localparam int unsigned N     = 7;
    localparam int unsigned W2    = 2 * N;
    localparam int unsigned CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    typedef struct packed {
        logic [N-1:0] quotient;
        logic [N-1:0] divider;
        logic [N-1:0] remainder;
    } operands_t;

endpackage

// File: rtl/dividend_rebuild_if.sv
// Request/result bundle between the requester and the dividend rebuild unit.
interface dividend_rebuild_if;
    import divrebuild_pkg::*;

    logic          start;
    logic [N-1:0]  quotient;
    logic [N-1:0]  divider;
    logic [N-1:0]  remainder;
    logic          busy;
    logic          done;
    logic [W2-1:0] dividend;
    logic          rem_err;

    modport master (
        output start, quotient, divider, remainder,
        input  busy, done, dividend, rem_err
    );

    modport slave (
        input  start, quotient, divider, remainder,
        output busy, done, dividend, rem_err
    );

endinterface

// File: rtl/dividend_rebuild_dp.sv
// Shift-add multiply-accumulate datapath: acc = remainder + quotient*divider over N steps.
module dividend_rebuild_dp
    import divrebuild_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic          i_step,
    input  operands_t     i_ops,
    output logic [W2-1:0] o_acc
);

    logic [W2-1:0] r_acc;
    logic [W2-1:0] r_mcand;
    logic [N-1:0]  r_mplier;
    logic [W2-1:0] w_sum;

    // Add the shifted multiplicand only when the current multiplier bit is set.
    assign w_sum = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_load) begin
            r_acc    <= W2'(i_ops.remainder);
            r_mcand  <= W2'(i_ops.divider);
            r_mplier <= i_ops.quotient;
        end else if (i_step) begin
            r_acc    <= w_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/dividend_rebuild.sv
// Rebuilds dividend = quotient*divider + remainder with a start/done handshake.
// Optional DIVREBUILD_REMCHECK_EN flags remainder >= divider (or divider == 0) alongside the result.
module dividend_rebuild
    import divrebuild_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    dividend_rebuild_if.slave  bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic [W2-1:0]    r_dividend;
    logic [W2-1:0]    w_dividend_nxt;
    logic             w_load;
    logic             w_step;
    logic [W2-1:0]    w_acc;
    operands_t        w_ops;

    assign w_ops.quotient  = bus.quotient;
    assign w_ops.divider   = bus.divider;
    assign w_ops.remainder = bus.remainder;

    dividend_rebuild_dp u_dp (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_step (w_step),
        .i_ops  (w_ops),
        .o_acc  (w_acc)
    );

    // Next-state, counter and output-register next values.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_done_nxt     = 1'b0;
        w_dividend_nxt = r_dividend;
        w_load         = 1'b0;
        w_step         = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                w_step    = 1'b1;
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(N - 1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_done_nxt     = 1'b1;
                w_dividend_nxt = w_acc;
                w_state_nxt    = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dividend <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_dividend <= w_dividend_nxt;
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.dividend = r_dividend;

`ifdef DIVREBUILD_REMCHECK_EN
    logic r_rem_err;
    logic w_rem_err_nxt;

    // Remainder sanity flag captured with the operands; held until the next acceptance.
    always_comb begin
        w_rem_err_nxt = r_rem_err;
        if (w_load) begin
            w_rem_err_nxt = (bus.remainder >= bus.divider) || (bus.divider == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem_err <= 1'b0;
        end else begin
            r_rem_err <= w_rem_err_nxt;
        end
    end

    assign bus.rem_err = r_rem_err;
`else
    assign bus.rem_err = 1'b0;
`endif

endmodule

// File: tb/tb_dividend_rebuild.sv
// Scoreboard bench for dividend_rebuild: directed vectors, queue of expected results, done monitor.
module tb_dividend_rebuild;
    import divrebuild_pkg::*;

    typedef struct {
        logic [W2-1:0] dv;
        logic          re;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dividend_rebuild_if bus ();

    dividend_rebuild dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t          exp_q[$];
    exp_t          e_mon;
    int            total = 0;
    int            bad   = 0;
    logic [W2-1:0] last_dv = '0;
    logic          prev_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    function automatic logic re_model(input logic rc);
`ifdef DIVREBUILD_REMCHECK_EN
        return rc;
`else
        return 1'b0 & rc;
`endif
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            if (bus.done) begin
                chk("done_single_pulse", 32'(prev_done), 0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got dividend %0d want no result", bus.dividend);
                end else begin
                    e_mon = exp_q.pop_front();
                    chk("dividend", 32'(bus.dividend), 32'(e_mon.dv));
                    chk("rem_err", 32'(bus.rem_err), 32'(e_mon.re));
                    last_dv = e_mon.dv;
                end
            end
            prev_done = bus.done;
        end
    end

    // Issue one operation and follow it to done; optionally pulse a second start mid-CALC.
    task automatic run_op(input logic [N-1:0] q, input logic [N-1:0] d, input logic [N-1:0] r,
                          input logic [W2-1:0] exp_dv, input logic rc, input logic inj);
        int   k;
        logic got;
        exp_t ex;
        bus.quotient  = q;
        bus.divider   = d;
        bus.remainder = r;
        bus.start     = 1'b1;
        ex.dv = exp_dv;
        ex.re = re_model(rc);
        exp_q.push_back(ex);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("busy_after_accept", 32'(bus.busy), 1);
        k   = 0;
        got = 1'b0;
        while (k < 20 && !got) begin
            @(posedge clk);
            #1;
            k++;
            if (inj && k == 2) begin
                bus.start     = 1'b1;
                bus.quotient  = 7'd9;
                bus.divider   = 7'd9;
                bus.remainder = 7'd9;
            end
            if (inj && k == 3) bus.start = 1'b0;
            if (bus.done) begin
                got = 1'b1;
            end else begin
                chk("busy_during_op", 32'(bus.busy), 1);
                chk("dividend_hold", 32'(bus.dividend), 32'(last_dv));
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done after %0d edges want %0d", k, N + 1);
        end else begin
            chk("latency", 32'(k), 32'(N + 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.quotient  = '0;
        bus.divider   = '0;
        bus.remainder = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_done", 32'(bus.done), 0);
        chk("reset_dividend", 32'(bus.dividend), 0);
        chk("reset_rem_err", 32'(bus.rem_err), 0);
        rst     = 1'b0;
        last_dv = '0;

        run_op(7'd2,   7'd5,   7'd1,   14'd11,    1'b0, 1'b0);
        run_op(7'd2,   7'd5,   7'd2,   14'd12,    1'b0, 1'b0);
        run_op(7'd5,   7'd3,   7'd0,   14'd15,    1'b0, 1'b0);
        run_op(7'd1,   7'd55,  7'd45,  14'd100,   1'b0, 1'b0);
        run_op(7'd127, 7'd127, 7'd127, 14'd16256, 1'b1, 1'b0);
        run_op(7'd0,   7'd0,   7'd9,   14'd9,     1'b1, 1'b0);
        // Mid-CALC start is ignored; the next start right after done is accepted.
        run_op(7'd3,   7'd4,   7'd2,   14'd14,    1'b0, 1'b1);
        run_op(7'd2,   7'd5,   7'd2,   14'd12,    1'b0, 1'b0);
        run_op(7'd3,   7'd5,   7'd5,   14'd20,    1'b1, 1'b0);
        run_op(7'd3,   7'd5,   7'd4,   14'd19,    1'b0, 1'b0);

        // Reset during the third CALC cycle aborts the operation with no done pulse.
        bus.quotient  = 7'd10;
        bus.divider   = 7'd10;
        bus.remainder = 7'd10;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midcalc_reset_busy", 32'(bus.busy), 0);
        chk("midcalc_reset_done", 32'(bus.done), 0);
        chk("midcalc_reset_dividend", 32'(bus.dividend), 0);
        chk("midcalc_reset_rem_err", 32'(bus.rem_err), 0);
        rst     = 1'b0;
        last_dv = '0;
        for (int i = 0; i < int'(N) + 4; i++) begin
            @(posedge clk);
            #1;
            chk("no_done_after_reset", 32'(bus.done), 0);
        end

        run_op(7'd1, 7'd55, 7'd45, 14'd100, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
